// File: rtl/slant_pkg.sv
// Shared definitions for the Slant line-code transmitter: sync words,
// sync_sel encodings, transmitter state enum, receiver decision threshold
// and the payload parity helper.
package slant_pkg;

  // 24-bit sync words, transmitted MSB first
  localparam logic [23:0] SYNC_FRAME_EVEN = 24'hAAB155;
  localparam logic [23:0] SYNC_FRAME_ODD  = 24'hAA8D55;
  localparam logic [23:0] SYNC_HSYNC      = 24'h00A355;

  // sync_sel encodings (both upper codes select hsync)
  localparam logic [1:0] SEL_FRAME_EVEN = 2'd0;
  localparam logic [1:0] SEL_FRAME_ODD  = 2'd1;
  localparam logic [1:0] SEL_HSYNC      = 2'd2;
  localparam logic [1:0] SEL_HSYNC_ALT  = 2'd3;

  // Receiver slicer threshold; HIGH_LEVEL must sit above it, LOW_LEVEL at or below
  localparam logic [7:0] RX_THRESHOLD = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_SYNC     = 2'd2,
    ST_PAYLOAD  = 2'd3
  } tx_state_e;

  // Even parity over one payload byte: XOR of the eight data bits
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  // Map a latched sync_sel code to its sync word
  function automatic logic [23:0] sync_word(input logic [1:0] sel);
    logic [23:0] word;
    case (sel)
      SEL_FRAME_EVEN: word = SYNC_FRAME_EVEN;
      SEL_FRAME_ODD:  word = SYNC_FRAME_ODD;
      SEL_HSYNC:      word = SYNC_HSYNC;
      SEL_HSYNC_ALT:  word = SYNC_HSYNC;
      default:        word = SYNC_HSYNC;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/slant_bit_timer.sv
// Bit timer for the Slant transmitter: counts 0..BIT_CYCLES-1 and flags the
// terminal count with bit_tick. restart holds the count at zero so the first
// bit of a request gets its full BIT_CYCLES period.
module slant_bit_timer #(
  parameter int BIT_CYCLES = 25
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic bit_tick
);

  // BIT_CYCLES is at most 256, so the terminal count always fits in 8 bits
  localparam logic [7:0] LAST_COUNT = 8'(BIT_CYCLES - 1);

  logic [7:0] count_r;

  // Modulo-BIT_CYCLES counter with synchronous restart
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= 8'd0;
    end else if (restart) begin
      count_r <= 8'd0;
    end else if (count_r == LAST_COUNT) begin
      count_r <= 8'd0;
    end else begin
      count_r <= count_r + 8'd1;
    end
  end

  assign bit_tick = (count_r == LAST_COUNT);

endmodule

// File: rtl/slant_sync_tx.sv
// Slant line-code transmitter. Per request it sends an alternating training
// preamble, a 24-bit sync word and byte_count payload bytes, each bit held
// for BIT_CYCLES clocks at HIGH_LEVEL or LOW_LEVEL on TxData.
// Optional build macro SLANT_TX_PARITY_EN appends an even-parity bit to
// every payload byte (9 bits per byte instead of 8).
module slant_sync_tx
  import slant_pkg::*;
#(
  parameter int         BIT_CYCLES    = 25,
  parameter int         PREAMBLE_BITS = 8,
  parameter logic [7:0] HIGH_LEVEL    = 8'hFF,
  parameter logic [7:0] LOW_LEVEL     = 8'h00
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [1:0] sync_sel,
  input  logic [7:0] byte_count,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] TxData,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_BITS - 1);
  localparam logic [7:0] SYNC_LAST = 8'd23;
`ifdef SLANT_TX_PARITY_EN
  localparam logic [7:0] BYTE_LAST = 8'd8;
`else
  localparam logic [7:0] BYTE_LAST = 8'd7;
`endif

  // Amplitude for one line bit
  function automatic logic [7:0] level_of(input logic b);
    return b ? HIGH_LEVEL : LOW_LEVEL;
  endfunction

  tx_state_e   state_r;
  logic [7:0]  bit_idx_r;
  logic [7:0]  byte_idx_r;
  logic [7:0]  byte_count_r;
  logic [1:0]  sync_sel_r;
  logic [23:0] sync_sh_r;
  logic [8:0]  shift_r;        // {data byte, parity slot}, MSB on the line next
  logic [7:0]  hold_r;
  logic        hold_full_r;
  logic [8:0]  slots_r;        // byte slots consumed: fetched bytes plus underruns
  logic        in_ready_r;
  logic [7:0]  tx_data_r;
  logic        busy_r;
  logic        done_r;
  logic        underrun_r;

  logic        idle_s;
  logic        start_ok_s;
  logic        bit_tick_s;
  logic        last_byte_s;
  logic [23:0] sync_word_s;
  logic        enter_sync_s;
  logic        boundary_s;
  logic        finish_s;
  logic        handshake_s;
  logic        underrun_s;
  logic [7:0]  load_byte_s;
  logic [8:0]  load_shift_s;
  logic        hold_full_next_s;
  logic [8:0]  slots_next_s;
  logic        active_next_s;
  logic        in_ready_next_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign start_ok_s  = idle_s && start;
  assign last_byte_s = (byte_idx_r == (byte_count_r - 8'd1));
  assign sync_word_s = sync_word(sync_sel_r);

  // The timer is held at zero while idle so a request starts on a fresh bit
  slant_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk     (clk),
    .rstn    (rstn),
    .restart (idle_s),
    .bit_tick(bit_tick_s)
  );

  // Decode the phase transitions that happen on this bit tick
  always_comb begin
    enter_sync_s = 1'b0;
    boundary_s   = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      ST_PREAMBLE: begin
        if (bit_tick_s && (bit_idx_r == PRE_LAST)) begin
          enter_sync_s = 1'b1;
        end else begin
          enter_sync_s = 1'b0;
        end
      end
      ST_SYNC: begin
        if (bit_tick_s && (bit_idx_r == SYNC_LAST)) begin
          if (byte_count_r == 8'd0) begin
            finish_s = 1'b1;
          end else begin
            boundary_s = 1'b1;
          end
        end else begin
          finish_s   = 1'b0;
          boundary_s = 1'b0;
        end
      end
      ST_PAYLOAD: begin
        if (bit_tick_s && (bit_idx_r == BYTE_LAST)) begin
          if (last_byte_s) begin
            finish_s = 1'b1;
          end else begin
            boundary_s = 1'b1;
          end
        end else begin
          finish_s   = 1'b0;
          boundary_s = 1'b0;
        end
      end
      default: begin
        enter_sync_s = 1'b0;
        boundary_s   = 1'b0;
        finish_s     = 1'b0;
      end
    endcase
  end

  // Holding-register handshake and next in_ready
  always_comb begin
    handshake_s = in_valid && in_ready_r;
    underrun_s  = boundary_s && !hold_full_r;
    load_byte_s = hold_full_r ? hold_r : 8'h00;
`ifdef SLANT_TX_PARITY_EN
    load_shift_s = {load_byte_s, even_parity(load_byte_s)};
`else
    load_shift_s = {load_byte_s, 1'b0};
`endif
    // A byte accepted on the same edge as an unload lands after the unload
    if (finish_s || idle_s) begin
      hold_full_next_s = 1'b0;
    end else if (boundary_s) begin
      hold_full_next_s = handshake_s;
    end else if (handshake_s) begin
      hold_full_next_s = 1'b1;
    end else begin
      hold_full_next_s = hold_full_r;
    end
    if (start_ok_s) begin
      slots_next_s = 9'd0;
    end else begin
      slots_next_s = slots_r + {8'd0, handshake_s} + {8'd0, underrun_s};
    end
    active_next_s = enter_sync_s ||
                    (((state_r == ST_SYNC) || (state_r == ST_PAYLOAD)) && !finish_s);
    in_ready_next_s = active_next_s && !hold_full_next_s &&
                      (slots_next_s < {1'b0, byte_count_r});
  end

  // Request FSM, line datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      bit_idx_r    <= 8'd0;
      byte_idx_r   <= 8'd0;
      byte_count_r <= 8'd0;
      sync_sel_r   <= SEL_FRAME_EVEN;
      sync_sh_r    <= 24'd0;
      shift_r      <= 9'd0;
      hold_r       <= 8'd0;
      hold_full_r  <= 1'b0;
      slots_r      <= 9'd0;
      in_ready_r   <= 1'b0;
      tx_data_r    <= LOW_LEVEL;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      underrun_r  <= underrun_s;
      hold_full_r <= hold_full_next_s;
      slots_r     <= slots_next_s;
      in_ready_r  <= in_ready_next_s;
      if (handshake_s) begin
        hold_r <= in_data;
      end
      case (state_r)
        ST_IDLE: begin
          tx_data_r <= LOW_LEVEL;
          busy_r    <= 1'b0;
          if (start) begin
            state_r      <= ST_PREAMBLE;
            sync_sel_r   <= sync_sel;
            byte_count_r <= byte_count;
            bit_idx_r    <= 8'd0;
            byte_idx_r   <= 8'd0;
            busy_r       <= 1'b1;
            tx_data_r    <= HIGH_LEVEL;   // preamble bit 0 is a 1
          end
        end
        ST_PREAMBLE: begin
          if (bit_tick_s) begin
            if (enter_sync_s) begin
              state_r   <= ST_SYNC;
              bit_idx_r <= 8'd0;
              sync_sh_r <= sync_word_s;
              tx_data_r <= level_of(sync_word_s[23]);
            end else begin
              // next bit i+1 is ~(i+1)[0], which equals i[0]
              bit_idx_r <= bit_idx_r + 8'd1;
              tx_data_r <= level_of(bit_idx_r[0]);
            end
          end
        end
        ST_SYNC: begin
          if (bit_tick_s) begin
            if (finish_s) begin
              state_r   <= ST_IDLE;
              tx_data_r <= LOW_LEVEL;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
            end else if (boundary_s) begin
              state_r    <= ST_PAYLOAD;
              bit_idx_r  <= 8'd0;
              byte_idx_r <= 8'd0;
              shift_r    <= load_shift_s;
              tx_data_r  <= level_of(load_shift_s[8]);
            end else begin
              bit_idx_r <= bit_idx_r + 8'd1;
              sync_sh_r <= {sync_sh_r[22:0], 1'b0};
              tx_data_r <= level_of(sync_sh_r[22]);
            end
          end
        end
        ST_PAYLOAD: begin
          if (bit_tick_s) begin
            if (finish_s) begin
              state_r   <= ST_IDLE;
              tx_data_r <= LOW_LEVEL;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
            end else if (boundary_s) begin
              bit_idx_r  <= 8'd0;
              byte_idx_r <= byte_idx_r + 8'd1;
              shift_r    <= load_shift_s;
              tx_data_r  <= level_of(load_shift_s[8]);
            end else begin
              bit_idx_r <= bit_idx_r + 8'd1;
              shift_r   <= {shift_r[7:0], 1'b0};
              tx_data_r <= level_of(shift_r[7]);
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          tx_data_r <= LOW_LEVEL;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_r;
  assign TxData   = tx_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign underrun = underrun_r;

endmodule
